// File: rtl/tail_light_pkg.sv
// Shared mode encodings and the thermometer-pattern helper for the tail-light sequencer.
package tail_light_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_LEFT  = 2'd1,
      MODE_RIGHT = 2'd2,
      MODE_HAZ   = 2'd3
   } mode_t;

   // Lowest `seq` bits set; wide enough for the 8-lamp maximum, callers slice to LAMPS.
   function automatic logic [7:0] therm(input logic [3:0] seq);
      logic [8:0] t;
      t = (9'd1 << seq) - 9'd1;
      return t[7:0];
   endfunction

endpackage

// File: rtl/tail_light_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks; restart clears the count.
module tail_light_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light controller: sequential turn signals, brake override, hazard flash and PWM dimming.
module tail_light_sequencer
   import tail_light_pkg::*;
#(
   parameter int LAMPS    = 3,
   parameter int TICK_DIV = 4,
   parameter int DIM_BITS = 4,
   parameter int DIM_DUTY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             brake,
   input  logic             hazard,
   input  logic             left,
   input  logic             right,
   input  logic             lights,
   output logic [LAMPS-1:0] lamp_l,
   output logic [LAMPS-1:0] lamp_r,
   output logic             step
);

   localparam int SEQ_W = $clog2(LAMPS + 1);
   localparam logic [SEQ_W-1:0]    SEQ_MAX = SEQ_W'(LAMPS);
   localparam logic [DIM_BITS-1:0] DUTY    = DIM_BITS'(DIM_DUTY);
   localparam logic [LAMPS-1:0]    ALL_ON  = '1;

   mode_t               mode;
   mode_t               mode_dec;
   logic [SEQ_W-1:0]    seq;
   logic                flash;
   logic [DIM_BITS-1:0] pwm;
   logic                tick;
   logic                restart;
   logic                dim;
   logic [7:0]          therm_full;
   logic [LAMPS-1:0]    therm_v;
   logic [LAMPS-1:0]    brake_v;
   logic [LAMPS-1:0]    raw_l;
   logic [LAMPS-1:0]    raw_r;

   tail_light_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   assign restart    = (mode_dec != mode);
   assign therm_full = therm(4'(seq));
   assign therm_v    = therm_full[LAMPS-1:0];
   assign brake_v    = brake ? ALL_ON : '0;
   assign dim        = lights && (pwm < DUTY);

   always_comb begin
      mode_dec = MODE_OFF;
      if (hazard || (left && right)) begin
         mode_dec = MODE_HAZ;
      end else if (left) begin
         mode_dec = MODE_LEFT;
      end else if (right) begin
         mode_dec = MODE_RIGHT;
      end else begin
         mode_dec = MODE_OFF;
      end
   end

   // Brake forces the non-turning side on; in hazard it also beats the flash.
   always_comb begin
      raw_l = '0;
      raw_r = '0;
      case (mode)
         MODE_OFF: begin
            raw_l = brake_v;
            raw_r = brake_v;
         end
         MODE_LEFT: begin
            raw_l = therm_v;
            raw_r = brake_v;
         end
         MODE_RIGHT: begin
            raw_l = brake_v;
            raw_r = therm_v;
         end
         MODE_HAZ: begin
            raw_l = (brake || flash) ? ALL_ON : '0;
            raw_r = raw_l;
         end
         default: begin
            raw_l = '0;
            raw_r = '0;
         end
      endcase
   end

   // A mode change restarts the pattern and takes precedence over a coincident tick.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mode   <= MODE_OFF;
         seq    <= '0;
         flash  <= 1'b0;
         pwm    <= '0;
         lamp_l <= '0;
         lamp_r <= '0;
         step   <= 1'b0;
      end else begin
         pwm    <= pwm + DIM_BITS'(1);
         step   <= tick;
         lamp_l <= raw_l | {LAMPS{dim}};
         lamp_r <= raw_r | {LAMPS{dim}};
         if (restart) begin
            mode  <= mode_dec;
            seq   <= '0;
            flash <= 1'b0;
         end else if (tick) begin
            seq   <= (seq == SEQ_MAX) ? '0 : seq + SEQ_W'(1);
            flash <= (mode == MODE_HAZ) ? ~flash : flash;
         end else begin
            seq   <= seq;
            flash <= flash;
         end
      end
   end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer with a cycle model feeding an expected-value queue.
module tb_tail_light_sequencer;

   logic       clk = 1'b0;
   logic       reset, brake, hazard, left, right, lights;
   logic [2:0] lamp_l, lamp_r;
   logic       step;

   typedef struct packed {
      logic [2:0] l;
      logic [2:0] r;
      logic       s;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   // Reference state: mode 0=off 1=left 2=right 3=hazard.
   int m_mode, m_pre, m_seq, m_pwm;
   bit m_flash;

   tail_light_sequencer #(.LAMPS(3), .TICK_DIV(4), .DIM_BITS(4), .DIM_DUTY(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .brake  (brake),
      .hazard (hazard),
      .left   (left),
      .right  (right),
      .lights (lights),
      .lamp_l (lamp_l),
      .lamp_r (lamp_r),
      .step   (step)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   // One clock: predict the outputs of the coming edge, advance the model, then compare.
   task automatic cycle();
      exp_t       e;
      logic [2:0] th, rl, rr;
      bit         tk;
      int         d;
      e = '0;
      if (!reset) begin
         m_mode = 0; m_pre = 0; m_seq = 0; m_pwm = 0; m_flash = 0;
      end else begin
         tk = (m_pre == 3);
         th = 3'((4'd1 << m_seq) - 4'd1);
         case (m_mode)
            1:       begin rl = th; rr = brake ? 3'b111 : 3'b000; end
            2:       begin rr = th; rl = brake ? 3'b111 : 3'b000; end
            3:       begin rl = (brake || m_flash) ? 3'b111 : 3'b000; rr = rl; end
            default: begin rl = brake ? 3'b111 : 3'b000; rr = rl; end
         endcase
         if (lights && m_pwm < 4) begin
            rl = 3'b111;
            rr = 3'b111;
         end
         e.l = rl; e.r = rr; e.s = tk;
         d = (hazard || (left && right)) ? 3 : left ? 1 : right ? 2 : 0;
         m_pwm = (m_pwm + 1) % 16;
         if (d != m_mode) begin
            m_mode = d; m_pre = 0; m_seq = 0; m_flash = 0;
         end else if (tk) begin
            m_pre = 0;
            m_seq = (m_seq == 3) ? 0 : m_seq + 1;
            if (m_mode == 3) m_flash = !m_flash;
         end else begin
            m_pre = m_pre + 1;
         end
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("lamp_l", lamp_l, e.l);
      check("lamp_r", lamp_r, e.r);
      check("step", {2'b00, step}, {2'b00, e.s});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int guard;
      reset = 1'b0; brake = 1'b0; hazard = 1'b0; left = 1'b0; right = 1'b0; lights = 1'b0;
      // 1: reset then idle
      run(2);
      reset = 1'b1;
      run(8);
      // 2: left sequence
      left = 1'b1;
      run(22);
      // 3: right with brake, brake dropped mid-sequence
      left = 1'b0; right = 1'b1; brake = 1'b1;
      run(10);
      brake = 1'b0;
      run(10);
      // 4: hazard, hazard+brake, then left&right acting as hazard
      right = 1'b0; hazard = 1'b1;
      run(14);
      brake = 1'b1;
      run(6);
      brake = 1'b0; hazard = 1'b0; left = 1'b1; right = 1'b1;
      run(14);
      // 5: dimming alone, then with a left sequence
      left = 1'b0; right = 1'b0; lights = 1'b1;
      run(20);
      left = 1'b1;
      run(20);
      // 6: switch left->right on the tick where seq is 2
      lights = 1'b0;
      guard = 0;
      while (!(m_mode == 1 && m_seq == 2 && m_pre == 3) && guard < 40) begin
         cycle();
         guard++;
      end
      compared++;
      assert (guard < 40) else begin
         mismatched++;
         $error("FAIL align_seq2: observed guard %0d expected below %0d", guard, 40);
      end
      left = 1'b0; right = 1'b1;
      run(12);
      reset = 1'b0;
      run(1);
      check("reset_l", lamp_l, 3'b000);
      check("reset_r", lamp_r, 3'b000);
      reset = 1'b1; right = 1'b0;
      run(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
